// File: rtl/mult_eu_arbiter.sv
// Shares one multiplier EU between two requesters; a 1-bit owner tag FIFO
// remembers who issued each in-flight op so in-order results route back.
module mult_eu_arbiter #(
  parameter int unsigned EU_CTL_LEN    = 4,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ROB_IDX_W     = 4,
  parameter int unsigned EXCEPT_CODE_W = 4,
  parameter int unsigned MAX_INFLIGHT  = 4,
  parameter bit          RR_ARBITER    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req0_valid_i,
  output logic                     req0_ready_o,
  input  logic [EU_CTL_LEN-1:0]    req0_ctl_i,
  input  logic [XLEN-1:0]          req0_rs1_i,
  input  logic [XLEN-1:0]          req0_rs2_i,
  input  logic [ROB_IDX_W-1:0]     req0_rob_idx_i,
  input  logic                     req1_valid_i,
  output logic                     req1_ready_o,
  input  logic [EU_CTL_LEN-1:0]    req1_ctl_i,
  input  logic [XLEN-1:0]          req1_rs1_i,
  input  logic [XLEN-1:0]          req1_rs2_i,
  input  logic [ROB_IDX_W-1:0]     req1_rob_idx_i,
  output logic                     eu_valid_o,
  input  logic                     eu_ready_i,
  output logic [EU_CTL_LEN-1:0]    eu_ctl_o,
  output logic [XLEN-1:0]          eu_rs1_o,
  output logic [XLEN-1:0]          eu_rs2_o,
  output logic [ROB_IDX_W-1:0]     eu_rob_idx_o,
  input  logic                     eu_valid_i,
  output logic                     eu_ready_o,
  input  logic [ROB_IDX_W-1:0]     eu_rob_idx_i,
  input  logic [XLEN-1:0]          eu_result_i,
  input  logic                     eu_except_raised_i,
  input  logic [EXCEPT_CODE_W-1:0] eu_except_code_i,
  output logic                     rsp0_valid_o,
  input  logic                     rsp0_ready_i,
  output logic [ROB_IDX_W-1:0]     rsp0_rob_idx_o,
  output logic [XLEN-1:0]          rsp0_result_o,
  output logic                     rsp0_except_raised_o,
  output logic [EXCEPT_CODE_W-1:0] rsp0_except_code_o,
  output logic                     rsp1_valid_o,
  input  logic                     rsp1_ready_i,
  output logic [ROB_IDX_W-1:0]     rsp1_rob_idx_o,
  output logic [XLEN-1:0]          rsp1_result_o,
  output logic                     rsp1_except_raised_o,
  output logic [EXCEPT_CODE_W-1:0] rsp1_except_code_o
);
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [MAX_INFLIGHT-1:0] tag_q;
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [CNT_W-1:0]        count_q;
  logic                    rr_pref_q;

  logic full, empty, grant, can_issue, issue_hs, pop;
  logic owner, owner_ready, res_valid;

  assign full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign empty = (count_q == '0);

  // With a single valid requester (or none) both modes collapse to the same pick.
  always_comb begin
    grant = !req0_valid_i && req1_valid_i;
    if (RR_ARBITER && req0_valid_i && req1_valid_i)
      grant = rr_pref_q;
  end

  // rst_ni gating keeps the issue-side outputs low while reset is held.
  assign can_issue    = rst_ni && eu_ready_i && !full && !flush_i;
  assign eu_valid_o   = rst_ni && (req0_valid_i || req1_valid_i) && !full && !flush_i;
  assign req0_ready_o = can_issue && !grant;
  assign req1_ready_o = can_issue && grant;
  assign issue_hs     = eu_valid_o && eu_ready_i;

  assign eu_ctl_o     = grant ? req1_ctl_i     : req0_ctl_i;
  assign eu_rs1_o     = grant ? req1_rs1_i     : req0_rs1_i;
  assign eu_rs2_o     = grant ? req1_rs2_i     : req0_rs2_i;
  assign eu_rob_idx_o = grant ? req1_rob_idx_i : req0_rob_idx_i;

  assign owner        = tag_q[head_q];
  assign owner_ready  = owner ? rsp1_ready_i : rsp0_ready_i;
  assign res_valid    = eu_valid_i && !empty && !flush_i;
  assign rsp0_valid_o = res_valid && !owner;
  assign rsp1_valid_o = res_valid && owner;
  assign eu_ready_o   = !empty && owner_ready && !flush_i;
  assign pop          = eu_valid_i && eu_ready_o;

  assign rsp0_rob_idx_o       = eu_rob_idx_i;
  assign rsp0_result_o        = eu_result_i;
  assign rsp0_except_raised_o = eu_except_raised_i;
  assign rsp0_except_code_o   = eu_except_code_i;
  assign rsp1_rob_idx_o       = eu_rob_idx_i;
  assign rsp1_result_o        = eu_result_i;
  assign rsp1_except_raised_o = eu_except_raised_i;
  assign rsp1_except_code_o   = eu_except_code_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rr_pref_q <= 1'b0;
    end else if (flush_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rr_pref_q <= 1'b0;
    end else begin
      if (issue_hs) begin
        tag_q[tail_q] <= grant;
        tail_q        <= tail_q + 1'b1;
        rr_pref_q     <= !grant;
      end
      if (pop)
        head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_W'(issue_hs) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_mult_eu_arbiter.sv
// Directed bench: round-robin DUT plus a fixed-priority DUT sharing the same inputs.
module tb_mult_eu_arbiter;
  localparam int CL = 4, XL = 32, RW = 4, EW = 4;

  logic clk = 1'b0;
  logic rst_ni, flush_i;
  logic req0_valid_i, req1_valid_i, eu_ready_i, eu_valid_i, rsp0_ready_i, rsp1_ready_i;
  logic [CL-1:0] req0_ctl_i, req1_ctl_i;
  logic [XL-1:0] req0_rs1_i, req0_rs2_i, req1_rs1_i, req1_rs2_i, eu_result_i;
  logic [RW-1:0] req0_rob_idx_i, req1_rob_idx_i, eu_rob_idx_i;
  logic          eu_except_raised_i;
  logic [EW-1:0] eu_except_code_i;

  logic req0_ready_o, req1_ready_o, eu_valid_o, eu_ready_o, rsp0_valid_o, rsp1_valid_o;
  logic [CL-1:0] eu_ctl_o;
  logic [XL-1:0] eu_rs1_o, eu_rs2_o, rsp0_result_o, rsp1_result_o;
  logic [RW-1:0] eu_rob_idx_o, rsp0_rob_idx_o, rsp1_rob_idx_o;
  logic          rsp0_except_raised_o, rsp1_except_raised_o;
  logic [EW-1:0] rsp0_except_code_o, rsp1_except_code_o;

  logic f_req0_ready, f_req1_ready, f_eu_valid, f_eu_ready, f_rsp0_valid, f_rsp1_valid;
  logic [CL-1:0] f_eu_ctl;
  logic [XL-1:0] f_eu_rs1, f_eu_rs2, f_rsp0_result, f_rsp1_result;
  logic [RW-1:0] f_eu_rob, f_rsp0_rob, f_rsp1_rob;
  logic          f_rsp0_exc, f_rsp1_exc;
  logic [EW-1:0] f_rsp0_code, f_rsp1_code;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_eu_arbiter #(.EU_CTL_LEN(CL), .XLEN(XL), .ROB_IDX_W(RW), .EXCEPT_CODE_W(EW),
                    .MAX_INFLIGHT(4), .RR_ARBITER(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_ctl_i(req0_ctl_i),
    .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_rob_idx_i(req0_rob_idx_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_ctl_i(req1_ctl_i),
    .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_rob_idx_i(req1_rob_idx_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o),
    .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_rob_idx_o(eu_rob_idx_o),
    .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_rob_idx_i(eu_rob_idx_i),
    .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i),
    .eu_except_code_i(eu_except_code_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_rob_idx_o(rsp0_rob_idx_o),
    .rsp0_result_o(rsp0_result_o), .rsp0_except_raised_o(rsp0_except_raised_o),
    .rsp0_except_code_o(rsp0_except_code_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_rob_idx_o(rsp1_rob_idx_o),
    .rsp1_result_o(rsp1_result_o), .rsp1_except_raised_o(rsp1_except_raised_o),
    .rsp1_except_code_o(rsp1_except_code_o)
  );

  mult_eu_arbiter #(.EU_CTL_LEN(CL), .XLEN(XL), .ROB_IDX_W(RW), .EXCEPT_CODE_W(EW),
                    .MAX_INFLIGHT(4), .RR_ARBITER(1'b0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(f_req0_ready), .req0_ctl_i(req0_ctl_i),
    .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_rob_idx_i(req0_rob_idx_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(f_req1_ready), .req1_ctl_i(req1_ctl_i),
    .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_rob_idx_i(req1_rob_idx_i),
    .eu_valid_o(f_eu_valid), .eu_ready_i(eu_ready_i), .eu_ctl_o(f_eu_ctl),
    .eu_rs1_o(f_eu_rs1), .eu_rs2_o(f_eu_rs2), .eu_rob_idx_o(f_eu_rob),
    .eu_valid_i(eu_valid_i), .eu_ready_o(f_eu_ready), .eu_rob_idx_i(eu_rob_idx_i),
    .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i),
    .eu_except_code_i(eu_except_code_i),
    .rsp0_valid_o(f_rsp0_valid), .rsp0_ready_i(rsp0_ready_i), .rsp0_rob_idx_o(f_rsp0_rob),
    .rsp0_result_o(f_rsp0_result), .rsp0_except_raised_o(f_rsp0_exc),
    .rsp0_except_code_o(f_rsp0_code),
    .rsp1_valid_o(f_rsp1_valid), .rsp1_ready_i(rsp1_ready_i), .rsp1_rob_idx_o(f_rsp1_rob),
    .rsp1_result_o(f_rsp1_result), .rsp1_except_raised_o(f_rsp1_exc),
    .rsp1_except_code_o(f_rsp1_code)
  );

  // An EU result must never arrive while nothing is in flight.
  always @(posedge clk) begin
    if (rst_ni && eu_valid_i) begin
      total++;
      if (dut.count_q == 0) begin
        bad++;
        $display("FAIL protocol_result_while_empty got count=0 exp count>0");
      end
    end
  end

  task automatic idle();
    flush_i = 0; req0_valid_i = 0; req1_valid_i = 0; eu_valid_i = 0;
    req0_ctl_i = 0; req0_rs1_i = 0; req0_rs2_i = 0; req0_rob_idx_i = 0;
    req1_ctl_i = 0; req1_rs1_i = 0; req1_rs2_i = 0; req1_rob_idx_i = 0;
    eu_rob_idx_i = 0; eu_result_i = 0; eu_except_raised_i = 0; eu_except_code_i = 0;
    eu_ready_i = 1; rsp0_ready_i = 1; rsp1_ready_i = 1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    idle();
    req0_valid_i = 1; req1_valid_i = 1;
    @(negedge clk); #1;
    total++; if (req0_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%0b exp=0", req0_ready_o); end
    total++; if (req1_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%0b exp=0", req1_ready_o); end
    total++; if (eu_valid_o !== 1'b0) begin bad++; $display("FAIL reset_eu_valid got=%0b exp=0", eu_valid_o); end
    total++; if ({eu_ready_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin bad++;
      $display("FAIL reset_result_side got=%b exp=000", {eu_ready_o, rsp0_valid_o, rsp1_valid_o}); end
    idle();
    rst_ni = 1;
  endtask

  task automatic test_single();
    @(negedge clk);
    idle();
    req0_valid_i = 1; req0_ctl_i = 4'h5; req0_rs1_i = 7; req0_rs2_i = 6; req0_rob_idx_i = 3;
    #1;
    total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL single_req0_ready got=%0b exp=1", req0_ready_o); end
    total++; if (req1_ready_o !== 1'b0) begin bad++; $display("FAIL single_req1_ready got=%0b exp=0", req1_ready_o); end
    total++; if (eu_valid_o !== 1'b1) begin bad++; $display("FAIL single_eu_valid got=%0b exp=1", eu_valid_o); end
    total++; if ({eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_rob_idx_o} !== {4'h5, 32'd7, 32'd6, 4'd3}) begin bad++;
      $display("FAIL single_eu_data got=%0h/%0d/%0d/%0d exp=5/7/6/3", eu_ctl_o, eu_rs1_o, eu_rs2_o, eu_rob_idx_o); end
    @(negedge clk);
    idle();
    eu_valid_i = 1; eu_result_i = 42; eu_rob_idx_i = 3;
    #1;
    total++; if (rsp0_valid_o !== 1'b1) begin bad++; $display("FAIL single_rsp0_valid got=%0b exp=1", rsp0_valid_o); end
    total++; if (rsp1_valid_o !== 1'b0) begin bad++; $display("FAIL single_rsp1_valid got=%0b exp=0", rsp1_valid_o); end
    total++; if (rsp0_result_o !== 32'd42 || rsp0_rob_idx_o !== 4'd3) begin bad++;
      $display("FAIL single_rsp0_data got=%0d/%0d exp=42/3", rsp0_result_o, rsp0_rob_idx_o); end
    total++; if (eu_ready_o !== 1'b1) begin bad++; $display("FAIL single_eu_ready got=%0b exp=1", eu_ready_o); end
  endtask

  task automatic do_flush();
    @(negedge clk);
    idle();
    flush_i = 1; req0_valid_i = 1; req1_valid_i = 1;
    #1;
    total++; if ({eu_valid_o, req0_ready_o, req1_ready_o} !== 3'b000) begin bad++;
      $display("FAIL flush_issue_suppressed got=%b exp=000", {eu_valid_o, req0_ready_o, req1_ready_o}); end
  endtask

  // Round-robin alternation, fixed priority, full FIFO, pop-while-full, wrap and in-order routing.
  task automatic test_rr_full();
    logic exp_g;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      req0_valid_i = 1; req0_rs1_i = 32'h100; req1_valid_i = 1; req1_rs1_i = 32'h200;
      #1;
      exp_g = (i % 2) == 1;
      total++; if (req0_ready_o !== !exp_g || req1_ready_o !== exp_g) begin bad++;
        $display("FAIL rr_grant_%0d got=%0b%0b exp=%0b%0b", i, req1_ready_o, req0_ready_o, exp_g, !exp_g); end
      total++; if (eu_rs1_o !== (exp_g ? 32'h200 : 32'h100)) begin bad++;
        $display("FAIL rr_eu_rs1_%0d got=%0h exp=%0h", i, eu_rs1_o, exp_g ? 32'h200 : 32'h100); end
      total++; if (f_req0_ready !== 1'b1 || f_req1_ready !== 1'b0) begin bad++;
        $display("FAIL fixed_grant_%0d got=%0b%0b exp=01", i, f_req1_ready, f_req0_ready); end
    end
    @(negedge clk);
    eu_valid_i = 1; eu_result_i = 1;
    #1;
    total++; if ({eu_valid_o, req0_ready_o, req1_ready_o} !== 3'b000) begin bad++;
      $display("FAIL full_blocks_issue got=%b exp=000", {eu_valid_o, req0_ready_o, req1_ready_o}); end
    total++; if (dut.tail_q !== 2'd0) begin bad++; $display("FAIL full_tail_wrap got=%0d exp=0", dut.tail_q); end
    total++; if (rsp0_valid_o !== 1'b1 || eu_ready_o !== 1'b1) begin bad++;
      $display("FAIL full_pop0 got rsp0=%0b eu_ready=%0b exp=1/1", rsp0_valid_o, eu_ready_o); end
    @(negedge clk);
    eu_result_i = 2;
    #1;
    total++; if (eu_valid_o !== 1'b1 || req0_ready_o !== 1'b1 || eu_rs1_o !== 32'h100) begin bad++;
      $display("FAIL resume_issue got v=%0b r0=%0b rs1=%0h exp=1/1/100", eu_valid_o, req0_ready_o, eu_rs1_o); end
    total++; if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin bad++;
      $display("FAIL route_second got=%0b%0b exp=10", rsp1_valid_o, rsp0_valid_o); end
    @(posedge clk); #1;
    total++; if (dut.tail_q !== 2'd1 || dut.count_q !== 3'd3) begin bad++;
      $display("FAIL push_pop_ptrs got tail=%0d count=%0d exp=1/3", dut.tail_q, dut.count_q); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      idle();
      eu_valid_i = 1; eu_result_i = 3 + j;
      #1;
      exp_g = (j == 1);
      total++; if (rsp1_valid_o !== exp_g || rsp0_valid_o !== !exp_g) begin bad++;
        $display("FAIL drain_route_%0d got=%0b%0b exp=%0b%0b", j, rsp1_valid_o, rsp0_valid_o, exp_g, !exp_g); end
      total++; if ((exp_g ? rsp1_result_o : rsp0_result_o) !== 32'(3 + j)) begin bad++;
        $display("FAIL drain_data_%0d got=%0d exp=%0d", j, exp_g ? rsp1_result_o : rsp0_result_o, 3 + j); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle();
    req1_valid_i = 1; req1_rs1_i = 11;
    #1;
    total++; if (req1_ready_o !== 1'b1) begin bad++; $display("FAIL bp_issue_req1 got=%0b exp=1", req1_ready_o); end
    @(negedge clk);
    idle();
    req0_valid_i = 1; req0_rs1_i = 12;
    #1;
    total++; if (req0_ready_o !== 1'b1) begin bad++; $display("FAIL bp_issue_req0 got=%0b exp=1", req0_ready_o); end
    @(negedge clk);
    idle();
    eu_valid_i = 1; eu_result_i = 77; rsp1_ready_i = 0;
    #1;
    total++; if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin bad++;
      $display("FAIL bp_rsp1_valid got=%0b%0b exp=10", rsp1_valid_o, rsp0_valid_o); end
    total++; if (eu_ready_o !== 1'b0) begin bad++; $display("FAIL bp_eu_ready_low got=%0b exp=0", eu_ready_o); end
    @(posedge clk); #1;
    total++; if (dut.count_q !== 3'd2) begin bad++; $display("FAIL bp_held_count got=%0d exp=2", dut.count_q); end
    @(negedge clk);
    rsp1_ready_i = 1;
    #1;
    total++; if (eu_ready_o !== 1'b1 || rsp1_result_o !== 32'd77) begin bad++;
      $display("FAIL bp_release got ready=%0b res=%0d exp=1/77", eu_ready_o, rsp1_result_o); end
    @(posedge clk); #1;
    total++; if (dut.count_q !== 3'd1) begin bad++; $display("FAIL bp_pop_count got=%0d exp=1", dut.count_q); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle();
      req0_valid_i = 1;
    end
    @(negedge clk);
    idle();
    flush_i = 1; req1_valid_i = 1; eu_valid_i = 1; eu_result_i = 5;
    #1;
    total++; if ({eu_valid_o, req1_ready_o, eu_ready_o, rsp0_valid_o, rsp1_valid_o} !== 5'b0) begin bad++;
      $display("FAIL flush_suppress got=%b exp=00000", {eu_valid_o, req1_ready_o, eu_ready_o, rsp0_valid_o, rsp1_valid_o}); end
    @(posedge clk); #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", dut.count_q); end
    @(negedge clk);
    idle();
    req1_valid_i = 1; req1_rs1_i = 3; req1_rob_idx_i = 5;
    #1;
    total++; if (req1_ready_o !== 1'b1 || eu_rob_idx_o !== 4'd5) begin bad++;
      $display("FAIL flush_next_req1 got=%0b rob=%0d exp=1/5", req1_ready_o, eu_rob_idx_o); end
    @(negedge clk);
    idle();
    eu_valid_i = 1; eu_result_i = 9; eu_rob_idx_i = 5; eu_except_raised_i = 1; eu_except_code_i = 2;
    #1;
    total++; if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin bad++;
      $display("FAIL flush_route_rsp1 got=%0b%0b exp=10", rsp1_valid_o, rsp0_valid_o); end
    total++; if ({rsp1_except_raised_o, rsp1_except_code_o, rsp1_rob_idx_o, rsp1_result_o} !== {1'b1, 4'd2, 4'd5, 32'd9}) begin bad++;
      $display("FAIL exc_forward got=%0b/%0d/%0d/%0d exp=1/2/5/9", rsp1_except_raised_o, rsp1_except_code_o, rsp1_rob_idx_o, rsp1_result_o); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_full();
    test_backpressure();
    test_flush();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
